// File: rtl/trdb_pkg.sv
// Shared trace-debug widths.
//   XLEN      : instruction address / trap value width
//   CAUSE_LEN : trap cause width
package trdb_pkg;
  localparam int unsigned XLEN      = 32;
  localparam int unsigned CAUSE_LEN = 5;
endpackage

// File: rtl/trdb_qual_pipe.sv
// trdb_qual_pipe: two-stage (tc = current, lc = last) qualification pipeline
// feeding the trace packet emitter. Each accepted retired instruction moves
// the tc stage into lc and loads the presented instruction into tc, tagging
// first-qualified / unqualified edges of trace regions and a periodic resync
// every RESYNC_MAX consecutive qualified entries.
//
// Ports
//   clk_i, rst_ni            : clock, async active-low reset
//   valid_i                  : retired instruction presented this cycle
//   nc_qualified_i           : filter verdict for the presented instruction
//   trace_en_i               : tracing enabled (0 forces unqualified)
//   stall_i                  : downstream back-pressure, freezes the pipe
//   iaddr_i, cause_i, tval_i,
//   priv_lvl_i, exception_i,
//   interrupt_i              : instruction payload
//   tc_valid_o               : tc stage loaded on the previous edge
//   tc_qualified_o,
//   lc_qualified_o           : registered stage qualification
//   tc_first_qualified_o     : start of a trace region
//   tc_unqualified_o         : end of a trace region
//   tc_resync_o              : tc entry closes a resync window
//   tc_* payload, lc_* payload : registered stage payloads
module trdb_qual_pipe
  import trdb_pkg::*;
#(
  parameter int unsigned RESYNC_MAX = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_i,
  input  logic                 nc_qualified_i,
  input  logic                 trace_en_i,
  input  logic                 stall_i,
  input  logic [XLEN-1:0]      iaddr_i,
  input  logic [CAUSE_LEN-1:0] cause_i,
  input  logic [XLEN-1:0]      tval_i,
  input  logic [1:0]           priv_lvl_i,
  input  logic                 exception_i,
  input  logic                 interrupt_i,
  output logic                 tc_valid_o,
  output logic                 tc_qualified_o,
  output logic                 lc_qualified_o,
  output logic                 tc_first_qualified_o,
  output logic                 tc_unqualified_o,
  output logic                 tc_resync_o,
  output logic [XLEN-1:0]      tc_iaddr_o,
  output logic [CAUSE_LEN-1:0] tc_cause_o,
  output logic [XLEN-1:0]      tc_tval_o,
  output logic [1:0]           tc_priv_lvl_o,
  output logic                 tc_exception_o,
  output logic                 tc_interrupt_o,
  output logic [XLEN-1:0]      lc_iaddr_o,
  output logic                 lc_exception_o,
  output logic                 lc_interrupt_o
);

  localparam logic [15:0] CNT_LAST = 16'(RESYNC_MAX - 1);

  logic step;
  logic q_in;

  // tc stage
  logic                 tc_valid_q,     tc_valid_d;
  logic                 tc_qual_q,      tc_qual_d;
  logic                 tc_resync_q,    tc_resync_d;
  logic [XLEN-1:0]      tc_iaddr_q,     tc_iaddr_d;
  logic [CAUSE_LEN-1:0] tc_cause_q,     tc_cause_d;
  logic [XLEN-1:0]      tc_tval_q,      tc_tval_d;
  logic [1:0]           tc_priv_q,      tc_priv_d;
  logic                 tc_exc_q,       tc_exc_d;
  logic                 tc_int_q,       tc_int_d;

  // lc stage
  logic                 lc_qual_q,      lc_qual_d;
  logic [XLEN-1:0]      lc_iaddr_q,     lc_iaddr_d;
  logic                 lc_exc_q,       lc_exc_d;
  logic                 lc_int_q,       lc_int_d;

  logic [15:0]          resync_cnt_q,   resync_cnt_d;

  assign step = valid_i && !stall_i;
  assign q_in = nc_qualified_i && trace_en_i;

  always_comb begin
    tc_valid_d   = step;
    tc_qual_d    = tc_qual_q;
    tc_resync_d  = tc_resync_q;
    tc_iaddr_d   = tc_iaddr_q;
    tc_cause_d   = tc_cause_q;
    tc_tval_d    = tc_tval_q;
    tc_priv_d    = tc_priv_q;
    tc_exc_d     = tc_exc_q;
    tc_int_d     = tc_int_q;
    lc_qual_d    = lc_qual_q;
    lc_iaddr_d   = lc_iaddr_q;
    lc_exc_d     = lc_exc_q;
    lc_int_d     = lc_int_q;
    resync_cnt_d = resync_cnt_q;

    if (step) begin
      lc_qual_d  = tc_qual_q;
      lc_iaddr_d = tc_iaddr_q;
      lc_exc_d   = tc_exc_q;
      lc_int_d   = tc_int_q;

      tc_qual_d  = q_in;
      tc_iaddr_d = iaddr_i;
      tc_cause_d = cause_i;
      tc_tval_d  = tval_i;
      tc_priv_d  = priv_lvl_i;
      tc_exc_d   = exception_i;
      tc_int_d   = interrupt_i;

      // A first-qualified entry restarts the window instead of counting,
      // so a resync can never coincide with the start of a region.
      if (!q_in || !tc_qual_q) begin
        resync_cnt_d = '0;
        tc_resync_d  = 1'b0;
      end else if (resync_cnt_q >= CNT_LAST) begin
        resync_cnt_d = '0;
        tc_resync_d  = 1'b1;
      end else begin
        resync_cnt_d = resync_cnt_q + 16'd1;
        tc_resync_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tc_valid_q   <= 1'b0;
      tc_qual_q    <= 1'b0;
      tc_resync_q  <= 1'b0;
      tc_iaddr_q   <= '0;
      tc_cause_q   <= '0;
      tc_tval_q    <= '0;
      tc_priv_q    <= '0;
      tc_exc_q     <= 1'b0;
      tc_int_q     <= 1'b0;
      lc_qual_q    <= 1'b0;
      lc_iaddr_q   <= '0;
      lc_exc_q     <= 1'b0;
      lc_int_q     <= 1'b0;
      resync_cnt_q <= '0;
    end else begin
      tc_valid_q   <= tc_valid_d;
      tc_qual_q    <= tc_qual_d;
      tc_resync_q  <= tc_resync_d;
      tc_iaddr_q   <= tc_iaddr_d;
      tc_cause_q   <= tc_cause_d;
      tc_tval_q    <= tc_tval_d;
      tc_priv_q    <= tc_priv_d;
      tc_exc_q     <= tc_exc_d;
      tc_int_q     <= tc_int_d;
      lc_qual_q    <= lc_qual_d;
      lc_iaddr_q   <= lc_iaddr_d;
      lc_exc_q     <= lc_exc_d;
      lc_int_q     <= lc_int_d;
      resync_cnt_q <= resync_cnt_d;
    end
  end

  assign tc_valid_o           = tc_valid_q;
  assign tc_qualified_o       = tc_qual_q;
  assign lc_qualified_o       = lc_qual_q;
  assign tc_first_qualified_o = tc_valid_q && tc_qual_q && !lc_qual_q;
  assign tc_unqualified_o     = tc_valid_q && lc_qual_q && !tc_qual_q;
  assign tc_resync_o          = tc_valid_q && tc_resync_q;
  assign tc_iaddr_o           = tc_iaddr_q;
  assign tc_cause_o           = tc_cause_q;
  assign tc_tval_o            = tc_tval_q;
  assign tc_priv_lvl_o        = tc_priv_q;
  assign tc_exception_o       = tc_exc_q;
  assign tc_interrupt_o       = tc_int_q;
  assign lc_iaddr_o           = lc_iaddr_q;
  assign lc_exception_o       = lc_exc_q;
  assign lc_interrupt_o       = lc_int_q;

endmodule
